arith_seq_ctrl: RTL and testbench
=================================

Name: arith_seq_ctrl

Overview:
- Sequencer in front of the arithmetic pipeline (the exp/div/GeLU/AGG unit). It owns the pipeline's input port and serialises two requesters onto it:
  - the top-k routing job: scores, then expert outputs;
  - the GeLU activation stream.
- It orders each routing job as exp+sum (mode 0), drain, normalise (mode 1), then aggregate (mode 3).
- It tags pipeline results so downstream can separate GeLU results from AGG results.

Parameters:
- K_MAX, 8, maximum experts per job; must be ≤ 8, the pipeline weight-buffer depth.
- DW, 16, data width (FP16).
- DRAIN, 4, idle cycles after the last mode-0 beat before the first mode-1 beat (adder settle time).
- PIPE_LAT, 2, cycles from pipe_in_valid to the matching pipe_out_valid.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- cfg_k  in  4  experts for next job, sampled at job start; 0 or >K_MAX is treated as K_MAX
- score_valid  in  1  top-k score stream valid
- score_ready  out  1  score stream ready
- score_data  in  DW  gating score
- agg_valid  in  1  expert-output stream valid
- agg_ready  out  1  expert-output stream ready
- agg_data  in  DW  expert output element
- agg_psum  in  DW  running partial sum
- agg_last  in  1  final element of the job
- gelu_valid  in  1  GeLU request valid
- gelu_ready  out  1  GeLU request ready
- gelu_data  in  DW  GeLU operand
- pipe_in_valid  out  1  pipeline issue strobe
- pipe_in_data  out  DW  pipeline operand
- pipe_in_psum  out  DW  pipeline psum (AGG only, else 0)
- pipe_in_mode  out  2  0 exp, 1 div, 2 GeLU, 3 AGG
- pipe_out_valid  in  1  pipeline result valid
- pipe_out_data  in  DW  pipeline result
- res_valid  out  1  tagged result valid
- res_data  out  DW  result
- res_kind  out  1  0 GeLU, 1 AGG
- busy  out  1  routing job in progress
- job_done  out  1  one-cycle pulse after the agg_last beat is issued

Behaviour:
- Reset (rst_n low at posedge): state IDLE; all outputs 0; score buffer, counters, tag shift register and arbitration bit cleared. Reset mid-job abandons the job. Results already in flight are dropped (tags cleared).
- Handshake: a transfer occurs when valid && ready on the same posedge. At most one pipe_in_valid beat per cycle. Only one ready is high in any cycle.
- Score buffer: K_MAX × DW registers; ld_cnt and iss_cnt are 4 bits.
- State IDLE:
  - Arbitration: if score_valid and gelu_valid are both high, the winner alternates. last_gelu=1 favours the job; last_gelu=0 favours GeLU.
  - GeLU win: gelu_ready=1; on transfer, issue {mode 2, gelu_data} in the same cycle (combinational pass-through, pipe_in_valid=gelu_valid&&gelu_ready). Set last_gelu=1. Stay in IDLE.
  - Job win: latch k = cfg_k, clear last_gelu, go to LOAD. No beat is accepted this cycle.
- State LOAD: score_ready=1. Store each accepted score at buffer[ld_cnt]. After the k-th accept, go to EXP.
- State EXP: issue {mode 0, buffer[iss_cnt]} every cycle, k cycles back to back. Then go to EDRAIN.
- State EDRAIN: pipe_in_valid=0 for exactly DRAIN cycles, then go to DIV.
- State DIV: issue {mode 1, buffer[iss_cnt]} every cycle for k cycles, then go to AGG.
- State AGG: agg_ready=1; each accept issues {mode 3, agg_data, agg_psum}. On an accept with agg_last=1: pulse job_done next cycle, go to IDLE. GeLU is never granted in EXP/EDRAIN/DIV/AGG, because a GeLU beat would reset the pipeline weight index.
- busy=1 in every state except IDLE.
- Idle-bus values: when pipe_in_valid=0, pipe_in_mode/data/psum are 0.
- Result tagging: a PIPE_LAT-deep shift register carries {issued, kind} per cycle; kind=1 for mode 3, kind=0 for mode 2. Modes 0/1 shift in issued=0.
  - res_valid = pipe_out_valid && tail.issued.
  - res_kind = tail.kind; res_data = pipe_out_data.
  - pipe_out_valid while tail.issued=0 is suppressed. This is not an error.
- Simultaneous events: score_valid arriving in LOAD for the next job is not accepted after the k-th score (score_ready drops the cycle after).

Test Plan:
1. Reset, cfg_k=3, scores 0x3C00/0x4000/0x4200, then 4 agg beats (last on 4th) -> pipe_in_mode sequence 0,0,0, then 4 idle cycles, then 1,1,1,3,3,3,3. job_done pulses once. busy falls with job_done.
2. Only gelu_valid, data 0x1234, 5 consecutive beats -> 5 mode-2 beats back to back. 5 res_valid with res_kind=0, each PIPE_LAT cycles after its issue.
3. score_valid and gelu_valid both held high from reset -> GeLU is granted first. Job starts next and GeLU waits until IDLE. Then a GeLU beat again precedes the second job.
4. cfg_k=0 -> 8 mode-0 and 8 mode-1 beats. cfg_k=9 -> same.
5. rst_n low for one cycle during DIV (iss_cnt=2) -> next cycle all outputs 0, state IDLE, no res_valid for the dropped in-flight beats. The next job runs correctly.
6. agg_valid toggling 1,0,1,0 with agg_last on the 3rd beat -> exactly 3 mode-3 issues. GeLU is blocked until job_done. res_kind=1 for each AGG result.

Source files
------------

// File: rtl/arith_seq_ctrl_if.sv
// Request/issue/result bundle between the arithmetic-pipeline sequencer,
// its two requesters (routing job and GeLU stream) and the pipeline itself.
interface arith_seq_ctrl_if #(
    parameter int DW = 16
);
    logic [3:0]    cfg_k;
    logic          score_valid;
    logic          score_ready;
    logic [DW-1:0] score_data;
    logic          agg_valid;
    logic          agg_ready;
    logic [DW-1:0] agg_data;
    logic [DW-1:0] agg_psum;
    logic          agg_last;
    logic          gelu_valid;
    logic          gelu_ready;
    logic [DW-1:0] gelu_data;
    logic          pipe_in_valid;
    logic [DW-1:0] pipe_in_data;
    logic [DW-1:0] pipe_in_psum;
    logic [1:0]    pipe_in_mode;
    logic          pipe_out_valid;
    logic [DW-1:0] pipe_out_data;
    logic          res_valid;
    logic [DW-1:0] res_data;
    logic          res_kind;
    logic          busy;
    logic          job_done;

    // Sequencer side
    modport slave (
        input  cfg_k, score_valid, score_data,
        input  agg_valid, agg_data, agg_psum, agg_last,
        input  gelu_valid, gelu_data,
        input  pipe_out_valid, pipe_out_data,
        output score_ready, agg_ready, gelu_ready,
        output pipe_in_valid, pipe_in_data, pipe_in_psum, pipe_in_mode,
        output res_valid, res_data, res_kind, busy, job_done
    );

    // Requester / pipeline side
    modport master (
        output cfg_k, score_valid, score_data,
        output agg_valid, agg_data, agg_psum, agg_last,
        output gelu_valid, gelu_data,
        output pipe_out_valid, pipe_out_data,
        input  score_ready, agg_ready, gelu_ready,
        input  pipe_in_valid, pipe_in_data, pipe_in_psum, pipe_in_mode,
        input  res_valid, res_data, res_kind, busy, job_done
    );
endinterface

// File: rtl/arith_seq_ctrl.sv
// Sequencer in front of the exp/div/GeLU/AGG pipeline. Serialises routing
// jobs (exp+sum, drain, normalise, aggregate) and GeLU requests onto the
// single pipeline input, and tags results as GeLU (0) or AGG (1).
module arith_seq_ctrl #(
    parameter int K_MAX    = 8,
    parameter int DW       = 16,
    parameter int DRAIN    = 4,
    parameter int PIPE_LAT = 2
) (
    input logic            clk,
    input logic            rst_n,
    arith_seq_ctrl_if.slave bus
);
    localparam int IW  = (K_MAX > 1) ? $clog2(K_MAX) : 1;
    localparam int DCW = (DRAIN > 1) ? $clog2(DRAIN) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_EXP,
        S_EDRAIN,
        S_DIV,
        S_AGG
    } state_t;

    state_t                state_q;
    logic [3:0]            k_q;
    logic [3:0]            ld_cnt_q;
    logic [3:0]            iss_cnt_q;
    logic [DCW-1:0]        drain_cnt_q;
    logic                  last_gelu_q;
    logic                  job_done_q;
    logic [DW-1:0]         score_buf_q [K_MAX];
    logic [PIPE_LAT-1:0]   tag_iss_q;
    logic [PIPE_LAT-1:0]   tag_kind_q;

    logic                  gelu_win;
    logic                  job_win;
    logic                  score_acc;
    logic                  agg_acc;
    logic                  last_iss;
    logic [3:0]            k_start;
    logic                  iss_valid;
    logic [1:0]            iss_mode;
    logic [DW-1:0]         iss_data;
    logic [DW-1:0]         iss_psum;

    // Arbitration: on contention the winner alternates via last_gelu_q.
    assign gelu_win  = (state_q == S_IDLE) && bus.gelu_valid && !(bus.score_valid && last_gelu_q);
    assign job_win   = (state_q == S_IDLE) && bus.score_valid && !gelu_win;
    assign score_acc = (state_q == S_LOAD) && bus.score_valid;
    assign agg_acc   = (state_q == S_AGG) && bus.agg_valid;
    assign last_iss  = (iss_cnt_q == k_q - 4'd1);
    assign k_start   = ((bus.cfg_k == 4'd0) || (bus.cfg_k > 4'(K_MAX))) ? 4'(K_MAX) : bus.cfg_k;

    // Pipeline issue mux; bus is held at zero when nothing is issued.
    always_comb begin
        iss_valid = 1'b0;
        iss_mode  = 2'd0;
        iss_data  = '0;
        iss_psum  = '0;
        case (state_q)
            S_IDLE: if (gelu_win) begin
                iss_valid = 1'b1;
                iss_mode  = 2'd2;
                iss_data  = bus.gelu_data;
            end
            S_EXP: begin
                iss_valid = 1'b1;
                iss_mode  = 2'd0;
                iss_data  = score_buf_q[iss_cnt_q[IW-1:0]];
            end
            S_DIV: begin
                iss_valid = 1'b1;
                iss_mode  = 2'd1;
                iss_data  = score_buf_q[iss_cnt_q[IW-1:0]];
            end
            S_AGG: if (agg_acc) begin
                iss_valid = 1'b1;
                iss_mode  = 2'd3;
                iss_data  = bus.agg_data;
                iss_psum  = bus.agg_psum;
            end
            default: ;
        endcase
    end

    // Job sequencing FSM: load scores, exp burst, drain, div burst, aggregate.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            k_q         <= '0;
            ld_cnt_q    <= '0;
            iss_cnt_q   <= '0;
            drain_cnt_q <= '0;
            last_gelu_q <= 1'b0;
            job_done_q  <= 1'b0;
            score_buf_q <= '{default: '0};
        end else begin
            job_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (gelu_win) begin
                        last_gelu_q <= 1'b1;
                    end else if (job_win) begin
                        k_q         <= k_start;
                        last_gelu_q <= 1'b0;
                        ld_cnt_q    <= '0;
                        state_q     <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (score_acc) begin
                        score_buf_q[ld_cnt_q[IW-1:0]] <= bus.score_data;
                        if (ld_cnt_q == k_q - 4'd1) begin
                            iss_cnt_q <= '0;
                            state_q   <= S_EXP;
                        end else begin
                            ld_cnt_q <= ld_cnt_q + 4'd1;
                        end
                    end
                end
                S_EXP: begin
                    if (last_iss) begin
                        drain_cnt_q <= '0;
                        state_q     <= S_EDRAIN;
                    end else begin
                        iss_cnt_q <= iss_cnt_q + 4'd1;
                    end
                end
                S_EDRAIN: begin
                    if (drain_cnt_q == DCW'(DRAIN - 1)) begin
                        iss_cnt_q <= '0;
                        state_q   <= S_DIV;
                    end else begin
                        drain_cnt_q <= drain_cnt_q + 1'b1;
                    end
                end
                S_DIV: begin
                    if (last_iss) begin
                        state_q <= S_AGG;
                    end else begin
                        iss_cnt_q <= iss_cnt_q + 4'd1;
                    end
                end
                S_AGG: begin
                    if (agg_acc && bus.agg_last) begin
                        job_done_q <= 1'b1;
                        state_q    <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Result tag shift register: {issued, kind} aligned to the pipeline latency.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tag_iss_q  <= '0;
            tag_kind_q <= '0;
        end else begin
            tag_iss_q  <= PIPE_LAT'({tag_iss_q, iss_valid && iss_mode[1]});
            tag_kind_q <= PIPE_LAT'({tag_kind_q, iss_valid && (iss_mode == 2'd3)});
        end
    end

    assign bus.score_ready   = (state_q == S_LOAD);
    assign bus.agg_ready     = (state_q == S_AGG);
    assign bus.gelu_ready    = gelu_win;
    assign bus.pipe_in_valid = iss_valid;
    assign bus.pipe_in_mode  = iss_mode;
    assign bus.pipe_in_data  = iss_data;
    assign bus.pipe_in_psum  = iss_psum;
    assign bus.res_valid     = bus.pipe_out_valid && tag_iss_q[PIPE_LAT-1];
    assign bus.res_kind      = tag_kind_q[PIPE_LAT-1];
    assign bus.res_data      = bus.pipe_out_data;
    assign bus.busy          = (state_q != S_IDLE);
    assign bus.job_done      = job_done_q;

endmodule

// File: tb/tb_arith_seq_ctrl.sv
// Scoreboard bench for arith_seq_ctrl: stimulus pushes expected pipeline
// beats, tagged results and job_done pulses (with their cycle numbers);
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_arith_seq_ctrl;
    localparam int DW       = 16;
    localparam int K_MAX    = 8;
    localparam int DRAIN    = 4;
    localparam int PIPE_LAT = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    arith_seq_ctrl_if #(.DW(DW)) bus ();

    arith_seq_ctrl #(
        .K_MAX   (K_MAX),
        .DW      (DW),
        .DRAIN   (DRAIN),
        .PIPE_LAT(PIPE_LAT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // Pipeline model: fixed 2-cycle latency, result = operand ^ 0x5A5A.
    logic          pv0 = 1'b0, pv1 = 1'b0;
    logic [15:0]   pd0 = '0,   pd1 = '0;
    always @(posedge clk) begin
        pv0 <= bus.pipe_in_valid;
        pd0 <= bus.pipe_in_data ^ 16'h5A5A;
        pv1 <= pv0;
        pd1 <= pd0;
    end
    assign bus.pipe_out_valid = pv1;
    assign bus.pipe_out_data  = pd1;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int c; logic [1:0] mode; logic [15:0] data; logic [15:0] psum; } beat_t;
    typedef struct { int c; logic kind; logic [15:0] data; } res_t;
    beat_t exp_q [$];
    res_t  res_q [$];
    int    done_q [$];

    int nchk = 0;
    int nerr = 0;
    bit mon_en = 1'b0;

    logic [15:0] tbl [8] = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400,
                             16'h4500, 16'h4600, 16'h4700, 16'h4800};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        nchk++;
        if (act !== req) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_beat(input int c, input logic [1:0] m, input logic [15:0] d, input logic [15:0] p);
        beat_t b;
        b.c = c; b.mode = m; b.data = d; b.psum = p;
        exp_q.push_back(b);
    endtask

    task automatic push_res(input int c, input logic k, input logic [15:0] d);
        res_t r;
        r.c = c; r.kind = k; r.data = d ^ 16'h5A5A;
        res_q.push_back(r);
    endtask

    function automatic logic [63:0] outs_vec();
        return {23'h0, bus.score_ready, bus.agg_ready, bus.gelu_ready, bus.pipe_in_valid,
                bus.pipe_in_mode, bus.pipe_in_data, bus.pipe_in_psum,
                bus.res_valid, bus.res_kind, bus.busy, bus.job_done};
    endfunction

    // Monitor: compare every DUT presentation against the scoreboard.
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.pipe_in_valid) begin
                if (exp_q.size() == 0) begin
                    chk("beat_unexpected",
                        {12'h0, 16'(cyc), 1'b0, bus.pipe_in_valid, bus.pipe_in_mode, bus.pipe_in_data, bus.pipe_in_psum},
                        64'h0);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    chk("pipe_beat",
                        {12'h0, 16'(cyc), 2'b0, bus.pipe_in_mode, bus.pipe_in_data, bus.pipe_in_psum},
                        {12'h0, 16'(e.c), 2'b0, e.mode, e.data, e.psum});
                end
            end else begin
                chk("idle_bus", {30'h0, bus.pipe_in_mode, bus.pipe_in_data, bus.pipe_in_psum}, 64'h0);
            end
            if (bus.res_valid) begin
                if (res_q.size() == 0) begin
                    chk("res_unexpected", {31'h0, 16'(cyc), bus.res_kind, bus.res_data}, 64'h0);
                end else begin
                    res_t r;
                    r = res_q.pop_front();
                    chk("res", {31'h0, 16'(cyc), bus.res_kind, bus.res_data},
                               {31'h0, 16'(r.c), r.kind, r.data});
                end
            end
            if (bus.job_done) begin
                if (done_q.size() == 0) begin
                    chk("done_unexpected", {48'h0, 16'(cyc)}, 64'h0);
                end else begin
                    int dc;
                    dc = done_q.pop_front();
                    chk("job_done", {48'h0, 16'(cyc)}, {48'h0, 16'(dc)});
                end
            end
            chk("ready_rules",
                {62'h0, (32'(bus.score_ready) + 32'(bus.agg_ready) + 32'(bus.gelu_ready)) > 32'd1,
                 bus.busy && bus.gelu_ready},
                64'h0);
        end
    end

    // One routing job; keff is the expected effective k after clamping.
    task automatic run_job(input logic [3:0] cfgk, input int keff, input int nagg,
                           input bit toggle, input bit gelu_late, input bit abort);
        int s, dv, a, t, j;
        logic v;
        logic [15:0] d, p;
        s = cyc;
        bus.cfg_k       = cfgk;
        bus.score_valid = 1'b1;
        bus.score_data  = 16'hFFFF;
        for (int i = 0; i < keff; i++) push_beat(s + 1 + keff + i, 2'd0, tbl[i], 16'h0);
        dv = s + 1 + 2 * keff + DRAIN;
        for (int i = 0; i < (abort ? 3 : keff); i++) push_beat(dv + i, 2'd1, tbl[i], 16'h0);
        step();
        chk("load_entry", {62'h0, bus.busy, bus.score_ready}, 64'h3);
        if (gelu_late) begin
            bus.gelu_valid = 1'b1;
            bus.gelu_data  = 16'h0BBB;
        end
        for (int i = 0; i < keff; i++) begin
            if (i != 0) step();
            bus.score_data = tbl[i];
        end
        step();
        bus.score_valid = 1'b0;
        if (abort) begin
            while (cyc < dv + 2) step();
            rst_n = 1'b0;
            step();
            rst_n = 1'b1;
            chk("abort_outputs", outs_vec(), 64'h0);
            return;
        end
        a = dv + keff;
        while (cyc < a) step();
        t = 0;
        j = 0;
        while (j < nagg) begin
            v = !toggle || (t % 2 == 0);
            d = v ? 16'(16'h1000 + j) : 16'hDEAD;
            p = v ? 16'(16'h2000 + j) : 16'hBEEF;
            bus.agg_valid = v;
            bus.agg_data  = d;
            bus.agg_psum  = p;
            bus.agg_last  = v && (j == nagg - 1);
            if (v) begin
                push_beat(cyc, 2'd3, d, p);
                push_res(cyc + PIPE_LAT, 1'b1, d);
                j++;
            end
            step();
            t++;
        end
        bus.agg_valid = 1'b0;
        bus.agg_last  = 1'b0;
        done_q.push_back(cyc);
        chk("busy_end", {63'h0, bus.busy}, 64'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int g;
        bus.cfg_k       = '0;
        bus.score_valid = 1'b0; bus.score_data = '0;
        bus.agg_valid   = 1'b0; bus.agg_data   = '0; bus.agg_psum = '0; bus.agg_last = 1'b0;
        bus.gelu_valid  = 1'b0; bus.gelu_data  = '0;
        step(3);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        chk("reset_outputs", outs_vec(), 64'h0);

        // 1: k=3 job, four AGG beats
        run_job(4'd3, 3, 4, 1'b0, 1'b0, 1'b0);
        step();

        // 2: five back-to-back GeLU beats
        for (int i = 0; i < 5; i++) begin
            bus.gelu_valid = 1'b1;
            bus.gelu_data  = 16'h1234;
            push_beat(cyc, 2'd2, 16'h1234, 16'h0);
            push_res(cyc + PIPE_LAT, 1'b0, 16'h1234);
            step();
        end
        bus.gelu_valid = 1'b0;
        step(3);

        // 3: contention from reset: GeLU, job, GeLU, job
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        bus.score_valid = 1'b1;
        bus.gelu_valid  = 1'b1;
        bus.gelu_data   = 16'h0AAA;
        push_beat(cyc, 2'd2, 16'h0AAA, 16'h0);
        push_res(cyc + PIPE_LAT, 1'b0, 16'h0AAA);
        step();
        run_job(4'd3, 3, 2, 1'b0, 1'b0, 1'b0);
        bus.score_valid = 1'b1;
        push_beat(cyc, 2'd2, 16'h0AAA, 16'h0);
        push_res(cyc + PIPE_LAT, 1'b0, 16'h0AAA);
        step();
        bus.gelu_valid = 1'b0;
        run_job(4'd2, 2, 1, 1'b0, 1'b0, 1'b0);
        step(3);

        // 4: cfg_k 0 and 9 both clamp to K_MAX
        run_job(4'd0, 8, 2, 1'b0, 1'b0, 1'b0);
        step();
        run_job(4'd9, 8, 2, 1'b0, 1'b0, 1'b0);
        step(3);

        // 5: reset drops an in-flight GeLU result, then aborts a job in DIV
        g = cyc;
        bus.gelu_valid = 1'b1;
        bus.gelu_data  = 16'h0CCC;
        push_beat(g, 2'd2, 16'h0CCC, 16'h0);
        step();
        bus.gelu_valid = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("dropped_res", {62'h0, bus.pipe_out_valid, bus.res_valid}, 64'h2);
        step(2);
        run_job(4'd4, 4, 0, 1'b0, 1'b0, 1'b1);
        step(3);
        run_job(4'd3, 3, 4, 1'b0, 1'b0, 1'b0);
        step(3);

        // 6: toggling agg_valid, GeLU pending throughout the job
        run_job(4'd2, 2, 3, 1'b1, 1'b1, 1'b0);
        push_beat(cyc, 2'd2, 16'h0BBB, 16'h0);
        push_res(cyc + PIPE_LAT, 1'b0, 16'h0BBB);
        step();
        bus.gelu_valid = 1'b0;

        step(6);
        chk("beats_left", 64'(exp_q.size()), 64'h0);
        chk("res_left",   64'(res_q.size()), 64'h0);
        chk("done_left",  64'(done_q.size()), 64'h0);
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
